// File: rtl/cb_policy_ctrl.sv
// Circuit-breaker policy controller: turns ML anomaly verdicts and host overrides
// into registered cb_mode/cb_param/cb_load commands for the order book.
module cb_policy_ctrl #(
  parameter int unsigned CONF_MIN    = 64,
  parameter int unsigned HOLDOFF     = 16,
  parameter int unsigned MAX_REFRESH = 3,
  parameter int unsigned ARM_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ml_valid,
  input  logic [1:0] i_ml_class,
  input  logic [7:0] i_ml_conf,
  input  logic       i_book_cb_active,
  input  logic       i_host_override_en,
  input  logic       i_host_load,
  input  logic [1:0] i_host_mode,
  input  logic [7:0] i_host_param,
  output logic [1:0] o_cb_mode,
  output logic [7:0] o_cb_param,
  output logic       o_cb_load,
  output logic [1:0] o_ctrl_state,
  output logic       o_arm_fault,
  output logic [7:0] o_drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_ARMED    = 2'b01,
    S_ENGAGED  = 2'b10,
    S_COOLDOWN = 2'b11
  } state_t;

  state_t     r_state;
  logic [1:0] r_cb_mode;
  logic [7:0] r_cb_param;
  logic       r_cb_load;
  logic       r_arm_fault;
  logic [7:0] r_drop_cnt;
  logic [1:0] r_cur_sev;
  logic [7:0] r_cur_conf;
  logic [7:0] r_refresh_cnt;
  logic [7:0] r_timer;
  logic [7:0] r_cd_cnt;

  logic w_host;
  logic w_act;
  logic w_low;
  logic w_preempt;
  logic w_refresh;
  logic w_ml_issue;
  logic w_drop;

  // Verdict qualification and per-state issue decision
  always_comb begin
    w_host     = i_host_load & i_host_override_en;
    w_act      = i_ml_valid && (i_ml_class != 2'b00) && (i_ml_conf >= 8'(CONF_MIN));
    w_low      = i_ml_valid && (i_ml_class != 2'b00) && (i_ml_conf < 8'(CONF_MIN));
    w_preempt  = w_act && (i_ml_class > r_cur_sev);
    w_refresh  = w_act && (i_ml_class == r_cur_sev) && (i_ml_conf > r_cur_conf) &&
                 (r_refresh_cnt < 8'(MAX_REFRESH));
    w_ml_issue = 1'b0;
    case (r_state)
      S_IDLE:              w_ml_issue = w_act;
      S_ARMED, S_ENGAGED:  w_ml_issue = w_preempt | w_refresh;
      S_COOLDOWN:          w_ml_issue = w_act && (i_ml_class == 2'b11);
      default:             w_ml_issue = 1'b0;
    endcase
    w_drop = w_low | (w_act & (w_host | ~w_ml_issue));
  end

  // Policy FSM with registered outputs; host override outranks ML verdicts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cb_mode     <= 2'b00;
      r_cb_param    <= 8'd0;
      r_cb_load     <= 1'b0;
      r_arm_fault   <= 1'b0;
      r_drop_cnt    <= 8'd0;
      r_cur_sev     <= 2'b00;
      r_cur_conf    <= 8'd0;
      r_refresh_cnt <= 8'd0;
      r_timer       <= 8'd0;
      r_cd_cnt      <= 8'd0;
    end else begin
      r_cb_load   <= 1'b0;
      r_arm_fault <= 1'b0;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_host) begin
        r_cb_load     <= 1'b1;
        r_cb_mode     <= i_host_mode;
        r_cb_param    <= i_host_param;
        r_cur_conf    <= i_host_param;
        r_refresh_cnt <= 8'd0;
        r_timer       <= 8'd0;
        r_cur_sev     <= i_host_mode;
        r_state       <= (i_host_mode == 2'b00) ? S_IDLE : S_ARMED;
      end else if (w_ml_issue) begin
        r_cb_load     <= 1'b1;
        r_cb_mode     <= i_ml_class;
        r_cb_param    <= i_ml_conf;
        r_cur_sev     <= i_ml_class;
        r_cur_conf    <= i_ml_conf;
        r_timer       <= 8'd0;
        r_state       <= S_ARMED;
        // Only a same-severity reload inside an engagement consumes refresh budget
        if (((r_state == S_ARMED) || (r_state == S_ENGAGED)) && !w_preempt) begin
          r_refresh_cnt <= r_refresh_cnt + 8'd1;
        end else begin
          r_refresh_cnt <= 8'd0;
        end
      end else begin
        case (r_state)
          S_ARMED: begin
            if (i_book_cb_active) begin
              r_state <= S_ENGAGED;
            end else if (r_timer >= 8'(ARM_TIMEOUT - 1)) begin
              r_arm_fault <= 1'b1;
              r_state     <= S_COOLDOWN;
              r_cd_cnt    <= 8'(HOLDOFF);
            end else begin
              r_timer <= r_timer + 8'd1;
            end
          end
          S_ENGAGED: begin
            if (!i_book_cb_active) begin
              r_state  <= S_COOLDOWN;
              r_cd_cnt <= 8'(HOLDOFF);
            end
          end
          S_COOLDOWN: begin
            if (r_cd_cnt <= 8'd1) begin
              r_cd_cnt  <= 8'd0;
              r_cur_sev <= 2'b00;
              r_state   <= S_IDLE;
            end else begin
              r_cd_cnt <= r_cd_cnt - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_cb_mode    = r_cb_mode;
  assign o_cb_param   = r_cb_param;
  assign o_cb_load    = r_cb_load;
  assign o_ctrl_state = r_state;
  assign o_arm_fault  = r_arm_fault;
  assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_cb_policy_ctrl.sv
// Bench for cb_policy_ctrl: directed scenarios plus randomized traffic, all
// compared each cycle against a rule-level reference model.
module tb_cb_policy_ctrl;

  localparam int CONF_MIN    = 64;
  localparam int HOLDOFF     = 16;
  localparam int MAX_REFRESH = 3;
  localparam int ARM_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ml_valid;
  logic [1:0] ml_class;
  logic [7:0] ml_conf;
  logic       book;
  logic       host_en;
  logic       host_load;
  logic [1:0] host_mode;
  logic [7:0] host_param;
  logic [1:0] cb_mode;
  logic [7:0] cb_param;
  logic       cb_load;
  logic [1:0] ctrl_state;
  logic       arm_fault;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state (plain integers, rules applied in priority order)
  int m_state, m_mode, m_param, m_load, m_fault, m_drop;
  int m_sev, m_conf, m_ref, m_age, m_cool;

  cb_policy_ctrl #(
    .CONF_MIN(CONF_MIN), .HOLDOFF(HOLDOFF),
    .MAX_REFRESH(MAX_REFRESH), .ARM_TIMEOUT(ARM_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ml_valid(ml_valid), .i_ml_class(ml_class), .i_ml_conf(ml_conf),
    .i_book_cb_active(book),
    .i_host_override_en(host_en), .i_host_load(host_load),
    .i_host_mode(host_mode), .i_host_param(host_param),
    .o_cb_mode(cb_mode), .o_cb_param(cb_param), .o_cb_load(cb_load),
    .o_ctrl_state(ctrl_state), .o_arm_fault(arm_fault), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_param = 0; m_load = 0; m_fault = 0; m_drop = 0;
    m_sev = 0; m_conf = 0; m_ref = 0; m_age = 0; m_cool = 0;
  endtask

  // One clock of the policy rules, applied to the inputs present at the edge
  task automatic model_update();
    bit host, act, low, ml_issue;
    int cls, cf;
    cls = int'(ml_class);
    cf  = int'(ml_conf);
    m_load = 0;
    m_fault = 0;
    if (rst) begin
      model_reset();
      return;
    end
    host = host_load && host_en;
    act  = ml_valid && cls != 0 && cf >= CONF_MIN;
    low  = ml_valid && cls != 0 && cf < CONF_MIN;
    ml_issue = 0;
    if (act && !host) begin
      if (m_state == 0) ml_issue = 1;
      else if (m_state == 3) ml_issue = (cls == 3);
      else ml_issue = (cls > m_sev) ||
                      (cls == m_sev && cf > m_conf && m_ref < MAX_REFRESH);
    end
    if (low || (act && !ml_issue)) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
    if (host) begin
      m_load = 1; m_mode = int'(host_mode); m_param = int'(host_param);
      m_conf = int'(host_param); m_ref = 0; m_age = 0;
      m_sev = int'(host_mode);
      m_state = (host_mode == 2'b00) ? 0 : 1;
    end else if (ml_issue) begin
      m_ref = ((m_state == 1 || m_state == 2) && cls == m_sev) ? m_ref + 1 : 0;
      m_load = 1; m_mode = cls; m_param = cf; m_sev = cls; m_conf = cf;
      m_age = 0; m_state = 1;
    end else if (m_state == 1) begin
      if (book) m_state = 2;
      else begin
        m_age++;
        if (m_age == ARM_TIMEOUT) begin m_fault = 1; m_state = 3; m_cool = HOLDOFF; end
      end
    end else if (m_state == 2) begin
      if (!book) begin m_state = 3; m_cool = HOLDOFF; end
    end else if (m_state == 3) begin
      m_cool--;
      if (m_cool == 0) begin m_state = 0; m_sev = 0; end
    end
  endtask

  // Advance one cycle, compare every output with the model, drop strobes
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("cb_mode",    {6'd0, cb_mode},    8'(m_mode));
    chk("cb_param",   cb_param,           8'(m_param));
    chk("cb_load",    {7'd0, cb_load},    8'(m_load));
    chk("ctrl_state", {6'd0, ctrl_state}, 8'(m_state));
    chk("arm_fault",  {7'd0, arm_fault},  8'(m_fault));
    chk("drop_cnt",   drop_cnt,           8'(m_drop));
    ml_valid  = 1'b0;
    host_load = 1'b0;
  endtask

  task automatic ml(input int cls, input int cf);
    ml_valid = 1'b1;
    ml_class = 2'(cls);
    ml_conf  = 8'(cf);
  endtask

  task automatic host(input int md, input int pr);
    host_en    = 1'b1;
    host_load  = 1'b1;
    host_mode  = 2'(md);
    host_param = 8'(pr);
  endtask

  initial begin
    int d0;
    rst = 1'b1; ml_valid = 1'b0; ml_class = 2'b00; ml_conf = 8'd0; book = 1'b0;
    host_en = 1'b0; host_load = 1'b0; host_mode = 2'b00; host_param = 8'd0;
    model_reset();
    step(); step();
    rst = 1'b0;
    chk("reset_state", {6'd0, ctrl_state}, 8'd0);
    chk("reset_drop", drop_cnt, 8'd0);

    // 1: flash crash from IDLE, book engages one cycle later
    ml(3, 200); step();
    chk("t1_load", {7'd0, cb_load}, 8'd1);
    chk("t1_mode", {6'd0, cb_mode}, 8'd3);
    chk("t1_param", cb_param, 8'd200);
    step();
    book = 1'b1; step();
    chk("t1_engaged", {6'd0, ctrl_state}, 8'd2);

    // 2: preempt from sev 01 to 10, then lower severity dropped
    host(0, 0); step();
    ml(1, 100); step(); step();
    chk("t2_engaged", {6'd0, ctrl_state}, 8'd2);
    ml(2, 90); step();
    chk("t2_preempt_load", {7'd0, cb_load}, 8'd1);
    chk("t2_preempt_mode", {6'd0, cb_mode}, 8'd2);
    step();
    d0 = m_drop;
    ml(1, 250); step();
    chk("t2_drop_load", {7'd0, cb_load}, 8'd0);
    chk("t2_drop_cnt", drop_cnt, 8'(d0 + 1));

    // 3: refresh budget of MAX_REFRESH reloads per engagement
    host(0, 0); step();
    ml(2, 80); step(); step();
    for (int i = 0; i < 4; i++) begin
      ml(2, 90 + 10 * i); step();
      chk("t3_refresh_load", {7'd0, cb_load}, (i < MAX_REFRESH) ? 8'd1 : 8'd0);
    end
    step();

    // 4: cooldown filters all but flash crash
    book = 1'b0; step();
    chk("t4_cooldown", {6'd0, ctrl_state}, 8'd3);
    repeat (3) step();
    d0 = m_drop;
    ml(1, 255); step();
    chk("t4_cd_drop_load", {7'd0, cb_load}, 8'd0);
    chk("t4_cd_drop_cnt", drop_cnt, 8'(d0 + 1));
    repeat (2) step();
    ml(3, 70); step();
    chk("t4_cd_fc_load", {7'd0, cb_load}, 8'd1);
    chk("t4_cd_fc_mode", {6'd0, cb_mode}, 8'd3);
    repeat (24) step();
    chk("t4_back_idle", {6'd0, ctrl_state}, 8'd0);

    // 5: confidence threshold edge and arm timeout
    d0 = m_drop;
    ml(2, 63); step();
    chk("t5_low_conf_load", {7'd0, cb_load}, 8'd0);
    chk("t5_low_conf_drop", drop_cnt, 8'(d0 + 1));
    ml(2, 64); step();
    chk("t5_min_conf_load", {7'd0, cb_load}, 8'd1);
    repeat (3) step();
    chk("t5_no_fault_yet", {7'd0, arm_fault}, 8'd0);
    step();
    chk("t5_arm_fault", {7'd0, arm_fault}, 8'd1);
    chk("t5_to_cooldown", {6'd0, ctrl_state}, 8'd3);
    repeat (18) step();

    // 6: host release beats a same-cycle flash crash verdict
    book = 1'b1;
    ml(3, 100); step(); step();
    d0 = m_drop;
    host(0, 5); ml(3, 200); step();
    chk("t6_load", {7'd0, cb_load}, 8'd1);
    chk("t6_mode", {6'd0, cb_mode}, 8'd0);
    chk("t6_idle", {6'd0, ctrl_state}, 8'd0);
    chk("t6_drop", drop_cnt, 8'(d0 + 1));

    // Host strobe without override enable, back-to-back issues, reset squashes load
    host(2, 9); host_en = 1'b0; step();
    chk("host_disabled", {7'd0, cb_load}, 8'd0);
    ml(1, 100); step();
    ml(2, 100); step();
    chk("b2b_second_load", {7'd0, cb_load}, 8'd1);
    ml(3, 200); rst = 1'b1; step();
    rst = 1'b0;
    chk("rst_no_load", {7'd0, cb_load}, 8'd0);
    chk("rst_state", {6'd0, ctrl_state}, 8'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) book = ~book;
      if ($urandom_range(0, 2) == 0) ml($urandom_range(0, 3), $urandom_range(0, 255));
      host_en = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 24) == 0) begin
        host_load  = 1'b1;
        host_mode  = 2'($urandom_range(0, 3));
        host_param = 8'($urandom_range(0, 255));
      end
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
